// File: rtl/switch_bounce_gen.sv
// Contact-bounce emulator: one shared engine turns clean per-switch target levels
// into bouncy switch waveforms, serving pending channels lowest index first.
//
// state  | meaning
// IDLE   | scanning for a channel whose output differs from its target
// BOUNCE | toggling the active channel with random holds between toggles
// SETTLE | final random hold, then drive the active channel to its current target
module switch_bounce_gen #(
  parameter int          N_SW         = 18,
  parameter int          BOUNCE_COUNT = 5,
  parameter int          HOLD_W       = 10,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [N_SW-1:0]         target,
  output logic [N_SW-1:0]         sw_out,
  output logic                    busy,
  output logic [$clog2(N_SW)-1:0] active_idx,
  output logic [N_SW-1:0]         settled
);

  localparam int          IDX_W  = $clog2(N_SW);
  localparam int          TCNT_W = $clog2(BOUNCE_COUNT + 1);
  localparam int          HCNT_W = HOLD_W + 1;
  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  state_t              state, state_nxt;
  logic [N_SW-1:0]     target_q, mismatch, sw_nxt, settled_nxt;
  logic [IDX_W-1:0]    idx_nxt, first_idx;
  logic                found;
  logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
  logic [HCNT_W-1:0]   hcnt, hcnt_nxt, hold;
  logic [15:0]         lfsr, lfsr_nxt;

  // Galois form of x^16+x^14+x^13+x^11+1; a nonzero state never reaches zero.
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign hold     = HCNT_W'(lfsr[HOLD_W-1:0]) + HCNT_W'(1);
  assign mismatch = target_q ^ sw_out;
  assign busy     = (state != IDLE);

  always_comb begin
    first_idx = '0;
    found     = 1'b0;
    for (int i = N_SW - 1; i >= 0; i--) begin
      if (mismatch[i]) begin
        first_idx = IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sw_out     <= '0;
      settled    <= '0;
      active_idx <= '0;
      tcnt       <= '0;
      hcnt       <= '0;
      lfsr       <= SEED;
      target_q   <= '0;
    end else begin
      state      <= state_nxt;
      sw_out     <= sw_nxt;
      settled    <= settled_nxt;
      active_idx <= idx_nxt;
      tcnt       <= tcnt_nxt;
      hcnt       <= hcnt_nxt;
      lfsr       <= lfsr_nxt;
      target_q   <= target;
    end
  end

  always_comb begin
    state_nxt   = state;
    sw_nxt      = sw_out;
    settled_nxt = '0;
    idx_nxt     = active_idx;
    tcnt_nxt    = tcnt;
    hcnt_nxt    = hcnt;
    if (!enable) begin
      state_nxt = IDLE;
      sw_nxt    = target;
      tcnt_nxt  = '0;
      hcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            idx_nxt           = first_idx;
            sw_nxt[first_idx] = ~sw_out[first_idx];
            tcnt_nxt          = TCNT_W'(1);
            hcnt_nxt          = hold;
            state_nxt         = BOUNCE;
          end
        end
        BOUNCE: begin
          if (hcnt == HCNT_W'(1)) begin
            hcnt_nxt = hold;
            if (tcnt < TCNT_W'(BOUNCE_COUNT)) begin
              sw_nxt[active_idx] = ~sw_out[active_idx];
              tcnt_nxt           = tcnt + TCNT_W'(1);
            end else begin
              state_nxt = SETTLE;
            end
          end else begin
            hcnt_nxt = hcnt - HCNT_W'(1);
          end
        end
        SETTLE: begin
          if (hcnt == HCNT_W'(1)) begin
            // Final level is whatever the target is now, not at burst start.
            sw_nxt[active_idx]      = target_q[active_idx];
            settled_nxt[active_idx] = 1'b1;
            state_nxt               = IDLE;
          end else begin
            hcnt_nxt = hcnt - HCNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
